// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared formats, field positions and types for instr_encoder
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'b00,
        FMT_I   = 2'b01,
        FMT_D   = 2'b10,
        FMT_BAD = 2'b11
    } fmt_t;

    // Index used when a select is not exactly one-hot (zero register)
    localparam logic [4:0] XZR_IDX = 5'd31;

    // Field LSB positions within the 32-bit instruction word
    localparam int OPC_LSB   = 21;
    localparam int IOPC_LSB  = 22;
    localparam int RM_LSB    = 16;
    localparam int SHAMT_LSB = 10;
    localparam int IMM_LSB   = 10;
    localparam int DADDR_LSB = 12;
    localparam int DOP_LSB   = 10;
    localparam int RN_LSB    = 5;
    localparam int RD_LSB    = 0;

    typedef struct packed {
        fmt_t        fmt;
        logic [10:0] opcode;
        logic [31:0] rd_sel;
        logic [31:0] rn_sel;
        logic [31:0] rm_sel;
        logic [5:0]  shamt;
        logic [11:0] imm12;
        logic [8:0]  dt_addr;
        logic [1:0]  dt_op;
    } fields_t;

endpackage

// File: rtl/instr_encoder_onehot_encoder.sv
// rtl/instr_encoder_onehot_encoder.sv - 32-bit one-hot to 5-bit index with exactly-one flag
module onehot_encoder (
    input  logic [31:0] sel,
    output logic [4:0]  idx,
    output logic        valid
);

    // OR together the indices of set bits; valid only when exactly one bit is set
    always_comb begin
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (sel[i]) idx = idx | 5'(i);
        end
        valid = (sel != '0) && ((sel & (sel - 32'd1)) == '0);
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - field set to 32-bit instruction encoder with output FIFO
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [10:0] opcode,
    input  logic [31:0] rd_sel,
    input  logic [31:0] rn_sel,
    input  logic [31:0] rm_sel,
    input  logic [5:0]  shamt,
    input  logic [11:0] imm12,
    input  logic [8:0]  dt_addr,
    input  logic [1:0]  dt_op,
    output logic [31:0] ibus,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sel_err,
    output logic        fmt_err,
    output logic [15:0] word_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    fields_t        in_fields;
    fields_t        s1;
    logic           s1_valid;
    logic           ready_en;
    logic [31:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW:0]    occ;
    logic           accept;
    logic           push;
    logic           pop;
    logic [4:0]     rd_raw, rn_raw, rm_raw;
    logic           rd_ok, rn_ok, rm_ok;
    logic [4:0]     rd_idx, rn_idx, rm_idx;
    logic [31:0]    word;
    logic           sel_bad;

    assign in_fields = '{fmt: fmt_t'(fmt), opcode: opcode, rd_sel: rd_sel, rn_sel: rn_sel,
                         rm_sel: rm_sel, shamt: shamt, imm12: imm12, dt_addr: dt_addr,
                         dt_op: dt_op};

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign occ       = {1'b0, count} + {{CW{1'b0}}, s1_valid};
    // Room is counted including the word still in stage 1, so the FIFO can never overflow
    assign in_ready  = ready_en && ((occ < DEPTH_V) || pop);
    assign accept    = in_valid && in_ready;
    assign push      = s1_valid && (s1.fmt != FMT_BAD);
    assign ibus      = out_valid ? mem[rd_ptr] : '0;

    onehot_encoder u_rd (.sel(s1.rd_sel), .idx(rd_raw), .valid(rd_ok));
    onehot_encoder u_rn (.sel(s1.rn_sel), .idx(rn_raw), .valid(rn_ok));
    onehot_encoder u_rm (.sel(s1.rm_sel), .idx(rm_raw), .valid(rm_ok));

    assign rd_idx = rd_ok ? rd_raw : XZR_IDX;
    assign rn_idx = rn_ok ? rn_raw : XZR_IDX;
    assign rm_idx = rm_ok ? rm_raw : XZR_IDX;

    // Assemble the word from stage 1; only selects the format uses can raise sel_bad
    always_comb begin
        word    = '0;
        sel_bad = 1'b0;
        case (s1.fmt)
            FMT_R: begin
                word = (32'(s1.opcode) << OPC_LSB) | (32'(rm_idx) << RM_LSB) |
                       (32'(s1.shamt) << SHAMT_LSB) | (32'(rn_idx) << RN_LSB) |
                       (32'(rd_idx) << RD_LSB);
                sel_bad = !(rd_ok && rn_ok && rm_ok);
            end
            FMT_I: begin
                word = (32'(s1.opcode[10:1]) << IOPC_LSB) | (32'(s1.imm12) << IMM_LSB) |
                       (32'(rn_idx) << RN_LSB) | (32'(rd_idx) << RD_LSB);
                sel_bad = !(rd_ok && rn_ok);
            end
            FMT_D: begin
                word = (32'(s1.opcode) << OPC_LSB) | (32'(s1.dt_addr) << DADDR_LSB) |
                       (32'(s1.dt_op) << DOP_LSB) | (32'(rn_idx) << RN_LSB) |
                       (32'(rd_idx) << RD_LSB);
                sel_bad = !(rd_ok && rn_ok);
            end
            default: ;
        endcase
    end

    // Stage 1 capture, FIFO bookkeeping, error pulses and delivered-word counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1         <= '0;
            s1_valid   <= 1'b0;
            ready_en   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            word_count <= '0;
            sel_err    <= 1'b0;
            fmt_err    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            s1_valid <= accept;
            if (accept) s1 <= in_fields;
            sel_err  <= s1_valid && sel_bad;
            fmt_err  <= s1_valid && (s1.fmt == FMT_BAD);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + PW'(1);
                word_count <= word_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // FIFO storage; contents are masked on ibus whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [10:0] opcode;
    logic [31:0] rd_sel, rn_sel, rm_sel;
    logic [5:0]  shamt;
    logic [11:0] imm12;
    logic [8:0]  dt_addr;
    logic [1:0]  dt_op;
    logic [31:0] ibus;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;
    logic        fmt_err;
    logic [15:0] word_count;

    int checks   = 0;
    int failures = 0;

    instr_encoder #(.FIFO_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd_sel(rd_sel), .rn_sel(rn_sel), .rm_sel(rm_sel),
        .shamt(shamt), .imm12(imm12), .dt_addr(dt_addr), .dt_op(dt_op),
        .ibus(ibus), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err), .fmt_err(fmt_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] f, input logic [10:0] op, input logic [31:0] rd,
                          input logic [31:0] rn, input logic [31:0] rm, input logic [5:0] sh,
                          input logic [11:0] im, input logic [8:0] da, input logic [1:0] dop);
        in_valid = 1'b1;
        fmt = f; opcode = op; rd_sel = rd; rn_sel = rn; rm_sel = rm;
        shamt = sh; imm12 = im; dt_addr = da; dt_op = dop;
    endtask

    task automatic send_one(input string tag, input logic [31:0] exp, input logic exp_sel,
                            input logic [15:0] exp_cnt);
        tick();
        in_valid = 1'b0;
        #1;
        check({tag, "_latency"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ibus"}, ibus, exp);
        check({tag, "_sel_err"}, 32'(sel_err), 32'(exp_sel));
        tick();
        check({tag, "_sel_err_gone"}, 32'(sel_err), 32'd0);
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
        check({tag, "_count"}, 32'(word_count), 32'(exp_cnt));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] got [4];
        logic [31:0] first;
        int acc, k, n, fe, se, stale;

        reset_n = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        fmt = '0; opcode = '0; rd_sel = '0; rn_sel = '0; rm_sel = '0;
        shamt = '0; imm12 = '0; dt_addr = '0; dt_op = '0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ibus", ibus, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_errs", 32'({sel_err, fmt_err}), 32'd0);
        reset_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(in_ready), 32'd0);
        tick();
        check("ready_after_edge", 32'(in_ready), 32'd1);

        // Single words through an empty pipeline
        out_ready = 1'b1;
        set_in(2'b00, 11'h458, 32'd1 << 1, 32'd1 << 2, 32'd1 << 3, 6'd0, 12'd0, 9'd0, 2'd0);
        send_one("r_type", 32'h8B030041, 1'b0, 16'd1);
        set_in(2'b01, 11'h488, 32'd1 << 0, 32'd1 << 1, 32'd0, 6'd0, 12'd5, 9'd0, 2'd0);
        send_one("i_type", 32'h91001420, 1'b0, 16'd2);
        set_in(2'b10, 11'h7C2, 32'd1 << 4, 32'h3, 32'd0, 6'd0, 12'd0, 9'd8, 2'd0);
        send_one("d_bad_sel", 32'hF84083E4, 1'b1, 16'd3);

        // Backpressure: only two words fit, then drain in order
        do_reset();
        out_ready = 1'b0;
        acc = 0; k = 0;
        for (int c = 0; c < 6; c++) begin
            set_in(2'b00, 11'h458, 32'd1 << k, 32'd1 << 2, 32'd1 << 3, 6'd0, 12'd0, 9'd0, 2'd0);
            #1;
            if (in_ready) begin acc++; k++; end
            tick();
        end
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head", ibus, 32'h8B030040);
        first = ibus;
        tick();
        tick();
        check("bp_stable_ibus", ibus, first);
        check("bp_stable_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            if (k < 4)
                set_in(2'b00, 11'h458, 32'd1 << k, 32'd1 << 2, 32'd1 << 3, 6'd0, 12'd0, 9'd0, 2'd0);
            else
                in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) k++;
            if (out_valid) begin got[n] = ibus; n++; end
            tick();
        end
        in_valid = 1'b0;
        check("bp_words", 32'(n), 32'd4);
        for (int i = 0; i < n; i++) check($sformatf("bp_word%0d", i), got[i], 32'h8B030040 | 32'(i));
        check("bp_word_count", 32'(word_count), 32'd4);

        // Illegal format between two legal words
        acc = 0; n = 0; fe = 0; se = 0;
        for (int c = 0; c < 10; c++) begin
            case (c)
                0: set_in(2'b00, 11'h458, 32'd1 << 1, 32'd1 << 2, 32'd1 << 3, 6'd0, 12'd0, 9'd0, 2'd0);
                1: set_in(2'b11, 11'h458, 32'd1 << 1, 32'd1 << 2, 32'd1 << 3, 6'd0, 12'd0, 9'd0, 2'd0);
                2: set_in(2'b00, 11'h458, 32'd1 << 2, 32'd1 << 2, 32'd1 << 3, 6'd0, 12'd0, 9'd0, 2'd0);
                default: in_valid = 1'b0;
            endcase
            #1;
            if (in_valid && in_ready) acc++;
            if (out_valid && n < 4) begin got[n] = ibus; n++; end
            if (fmt_err) fe++;
            if (sel_err) se++;
            tick();
        end
        check("fmt_accepted", 32'(acc), 32'd3);
        check("fmt_words", 32'(n), 32'd2);
        check("fmt_word0", got[0], 32'h8B030041);
        check("fmt_word1", got[1], 32'h8B030042);
        check("fmt_err_pulses", 32'(fe), 32'd1);
        check("fmt_sel_err_pulses", 32'(se), 32'd0);
        check("fmt_word_count", 32'(word_count), 32'd6);

        // Reset with words buffered
        out_ready = 1'b0;
        set_in(2'b00, 11'h458, 32'd1 << 5, 32'd1 << 2, 32'd1 << 3, 6'd0, 12'd0, 9'd0, 2'd0);
        tick();
        set_in(2'b00, 11'h458, 32'd1 << 6, 32'd1 << 2, 32'd1 << 3, 6'd0, 12'd0, 9'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_buffered", 32'(out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ibus", ibus, 32'd0);
        check("mid_rst_count", 32'(word_count), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) stale++;
            tick();
        end
        check("mid_no_stale", 32'(stale), 32'd0);
        check("mid_count_after", 32'(word_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
